sseg_scan_capture: RTL and testbench

Receive-side monitor for the multiplexed seven-segment bus (`an`/`sseg`, both active-low) that our animation and display drivers produce. It samples the scanned bus and rejects transitional glitches with a stability filter. It reconstructs the per-digit segment image into an 8-slot register file and reports frame completion, idle bus and multi-anode faults. It sits beside any display driver in the design and in the bench as a self-checking observer.

---
 rtl/sseg_pkg.sv | 50 +++++
 rtl/sseg_hex_decode.sv | 22 ++
 rtl/sseg_scan_capture.sv | 140 ++++++++++++++
 tb/tb_sseg_scan_capture.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/sseg_pkg.sv
// Shared constants, glyph table and FSM/classification types for the seven-segment bus monitor.
// The glyph table is used only when SSEG_CAP_HEX_EN is defined.
package sseg_pkg;

  localparam logic [7:0] SSEG_BLANK = 8'hFF;
  localparam logic [7:0] SSEG_TOP   = 8'b1001_1100;
  localparam logic [7:0] SSEG_BOT   = 8'b1010_0011;
  localparam logic [7:0] AN_OFF     = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_HELD
  } cap_state_e;

  typedef enum logic [1:0] {
    AN_NONE,
    AN_ONE,
    AN_MULTI
  } an_class_e;

  // Common-anode, active-low {g,f,e,d,c,b,a}; dp is not part of the glyph.
  function automatic logic [6:0] hex_glyph(input logic [3:0] n);
    case (n)
      4'h0: return 7'h40;
      4'h1: return 7'h79;
      4'h2: return 7'h24;
      4'h3: return 7'h30;
      4'h4: return 7'h19;
      4'h5: return 7'h12;
      4'h6: return 7'h02;
      4'h7: return 7'h78;
      4'h8: return 7'h00;
      4'h9: return 7'h10;
      4'hA: return 7'h08;
      4'hB: return 7'h03;
      4'hC: return 7'h46;
      4'hD: return 7'h21;
      4'hE: return 7'h06;
      default: return 7'h0E;
    endcase
  endfunction

  function automatic an_class_e classify(input logic [7:0] an);
    if (an == AN_OFF) return AN_NONE;
    if ($onehot(~an)) return AN_ONE;
    return AN_MULTI;
  endfunction

endpackage

// File: rtl/sseg_hex_decode.sv
// Maps one captured segment pattern to its hex nibble; dp is ignored.
// Anything that is not a hex glyph decodes as nibble 0 with ok low.
module sseg_hex_decode
  import sseg_pkg::*;
(
  input  logic [7:0] pattern,
  output logic [3:0] nibble,
  output logic       ok
);

  always_comb begin
    nibble = 4'h0;
    ok     = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (pattern[6:0] == hex_glyph(4'(i))) begin
        nibble = 4'(i);
        ok     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sseg_scan_capture.sv
// Receive-side monitor for the scanned an/sseg bus: stability filter, per-digit capture, frame/idle/fault reporting.
// Define SSEG_CAP_HEX_EN to add the per-slot hex decode; otherwise hex/hex_ok are tied low.
//
// state  | meaning
// IDLE   | no anode, multiple anodes, or reset; nothing to capture
// SETTLE | single anode seen, counting identical samples
// HELD   | current sample already captured; wait for the bus to change
module sseg_scan_capture
  import sseg_pkg::*;
#(
  parameter int unsigned STABLE_CYC = 4,
  parameter int unsigned IDLE_CYC   = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  an,
  input  logic [7:0]  sseg,
  output logic [63:0] seg_q,
  output logic [7:0]  digit_valid,
  output logic [7:0]  frame_mask,
  output logic        frame_strobe,
  output logic [31:0] hex,
  output logic [7:0]  hex_ok,
  output logic        idle,
  output logic        multi_err,
  output logic [7:0]  err_cnt
);

  localparam int unsigned IW = $clog2(IDLE_CYC + 1);

  logic [7:0]    an_s, sseg_s, an_p, sseg_p;
  cap_state_e    state, state_nx;
  logic [7:0]    stab_cnt, stab_cnt_nx;
  logic          capture;
  logic          changed;
  an_class_e     cls, cls_p;
  logic [7:0]    sel;
  logic [7:0]    run_mask;
  logic [IW-1:0] idle_cnt, idle_cnt_nx;

  assign cls     = classify(an_s);
  assign cls_p   = classify(an_p);
  assign changed = (an_s != an_p) || (sseg_s != sseg_p);
  assign sel     = ~an_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      an_s     <= AN_OFF;
      sseg_s   <= SSEG_BLANK;
      an_p     <= AN_OFF;
      sseg_p   <= SSEG_BLANK;
      state    <= ST_IDLE;
      stab_cnt <= 8'd0;
    end else begin
      an_s     <= an;
      sseg_s   <= sseg;
      an_p     <= an_s;
      sseg_p   <= sseg_s;
      state    <= state_nx;
      stab_cnt <= stab_cnt_nx;
    end
  end

  // A change always restarts the filter; with STABLE_CYC=1 the first ONE sample captures at once.
  always_comb begin
    state_nx    = state;
    stab_cnt_nx = stab_cnt;
    capture     = 1'b0;
    if (changed) begin
      state_nx    = (cls == AN_ONE) ? ST_SETTLE : ST_IDLE;
      stab_cnt_nx = (cls == AN_ONE) ? 8'd1 : 8'd0;
    end else if (state == ST_SETTLE) begin
      stab_cnt_nx = stab_cnt + 8'd1;
    end
    if (state_nx == ST_SETTLE && stab_cnt_nx == 8'(STABLE_CYC)) begin
      capture  = 1'b1;
      state_nx = ST_HELD;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seg_q        <= {8{SSEG_BLANK}};
      digit_valid  <= 8'h00;
      run_mask     <= 8'h00;
      frame_mask   <= 8'h00;
      frame_strobe <= 1'b0;
    end else begin
      frame_strobe <= 1'b0;
      if (capture) begin
        for (int i = 0; i < 8; i++) begin
          if (sel[i]) seg_q[8*i +: 8] <= sseg_s;
        end
        digit_valid <= digit_valid | sel;
        if ((run_mask & sel) != 8'h00) begin
          frame_strobe <= 1'b1;
          frame_mask   <= run_mask;
          run_mask     <= sel;
        end else begin
          run_mask <= run_mask | sel;
        end
      end
    end
  end

  always_comb begin
    idle_cnt_nx = idle_cnt;
    if (cls != AN_NONE) idle_cnt_nx = '0;
    else if (idle_cnt != IW'(IDLE_CYC)) idle_cnt_nx = idle_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idle_cnt  <= '0;
      idle      <= 1'b0;
      multi_err <= 1'b0;
      err_cnt   <= 8'd0;
    end else begin
      idle_cnt  <= idle_cnt_nx;
      idle      <= (idle_cnt_nx == IW'(IDLE_CYC));
      multi_err <= (cls == AN_MULTI) && (cls_p != AN_MULTI);
      if ((cls == AN_MULTI) && (cls_p != AN_MULTI) && (err_cnt != 8'hFF))
        err_cnt <= err_cnt + 8'd1;
    end
  end

`ifdef SSEG_CAP_HEX_EN
  for (genvar i = 0; i < 8; i++) begin : g_dec
    sseg_hex_decode u_dec (
      .pattern (seg_q[8*i +: 8]),
      .nibble  (hex[4*i +: 4]),
      .ok      (hex_ok[i])
    );
  end
`else
  assign hex    = 32'h0;
  assign hex_ok = 8'h00;
`endif

endmodule

// File: tb/tb_sseg_scan_capture.sv
// Directed self-checking bench for sseg_scan_capture (STABLE_CYC=4, IDLE_CYC=16).
// Hex expectations follow SSEG_CAP_HEX_EN so the same bench covers both builds.
module tb_sseg_scan_capture;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  an;
  logic [7:0]  sseg;
  logic [63:0] seg_q;
  logic [7:0]  digit_valid;
  logic [7:0]  frame_mask;
  logic        frame_strobe;
  logic [31:0] hex;
  logic [7:0]  hex_ok;
  logic        idle;
  logic        multi_err;
  logic [7:0]  err_cnt;

`ifdef SSEG_CAP_HEX_EN
  localparam bit HEX_ON = 1'b1;
`else
  localparam bit HEX_ON = 1'b0;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int strobe_cnt;
  int multi_cnt;
  logic [7:0] strobe_mask;
  logic [7:0] strobe_slot0;

  always #5 clk = ~clk;

  sseg_scan_capture #(.STABLE_CYC(4), .IDLE_CYC(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .an           (an),
    .sseg         (sseg),
    .seg_q        (seg_q),
    .digit_valid  (digit_valid),
    .frame_mask   (frame_mask),
    .frame_strobe (frame_strobe),
    .hex          (hex),
    .hex_ok       (hex_ok),
    .idle         (idle),
    .multi_err    (multi_err),
    .err_cnt      (err_cnt)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (frame_strobe) begin
      strobe_cnt++;
      strobe_mask  = frame_mask;
      strobe_slot0 = seg_q[7:0];
    end
    if (multi_err) multi_cnt++;
  endtask

  task automatic drive(input logic [7:0] a, input logic [7:0] s, input int n);
    an   = a;
    sseg = s;
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    an   = 8'hFF;
    sseg = 8'hFF;
    for (int k = 0; k < 3; k++) step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    an = 8'hFF;
    sseg = 8'hFF;
    strobe_cnt = 0;
    multi_cnt = 0;
    strobe_mask = 8'h00;
    strobe_slot0 = 8'h00;
    do_reset();

    check_val("rst_seg_q", seg_q, 64'hFFFF_FFFF_FFFF_FFFF);
    check_val("rst_valid", digit_valid, 8'h00);
    check_val("rst_idle", idle, 1'b0);

    // stability filter: 3-sample glitch, then a real 4-sample hold
    drive(8'hFE, 8'hC0, 3);
    drive(8'hFF, 8'hFF, 3);
    check_val("glitch_valid", digit_valid, 8'h00);
    check_val("glitch_seg_q", seg_q, 64'hFFFF_FFFF_FFFF_FFFF);
    drive(8'hFE, 8'hC0, 4);
    check_val("pre_cap_valid", digit_valid, 8'h00);
    step();
    check_val("cap_valid", digit_valid, 8'h01);
    check_val("cap_seg_q", seg_q, 64'hFFFF_FFFF_FFFF_FFC0);
    check_val("cap_hex", hex, 32'h0);
    check_val("cap_hex_ok", hex_ok, HEX_ON ? 8'h01 : 8'h00);
    drive(8'hFF, 8'hFF, 2);

    // multi-anode faults separated by a single ONE sample
    multi_cnt = 0;
    drive(8'hFC, 8'hF9, 5);
    drive(8'hFE, 8'hF9, 1);
    drive(8'hFC, 8'hF9, 5);
    drive(8'hFF, 8'hFF, 3);
    check_val("multi_pulses", multi_cnt, 2);
    check_val("multi_err_cnt", err_cnt, 8'd2);
    check_val("multi_seg_q", seg_q, 64'hFFFF_FFFF_FFFF_FFC0);
    check_val("multi_valid", digit_valid, 8'h01);

    // reset asserted at sample 2 of 4
    drive(8'hFD, 8'hA4, 2);
    rst = 1'b1;
    step();
    step();
    check_val("mrst_seg_q", seg_q, 64'hFFFF_FFFF_FFFF_FFFF);
    check_val("mrst_valid", digit_valid, 8'h00);
    check_val("mrst_fmask", frame_mask, 8'h00);
    check_val("mrst_strobe", frame_strobe, 1'b0);
    check_val("mrst_idle", idle, 1'b0);
    check_val("mrst_merr", multi_err, 1'b0);
    check_val("mrst_err_cnt", err_cnt, 8'd0);
    check_val("mrst_hex", hex, 32'h0);
    check_val("mrst_hex_ok", hex_ok, 8'h00);
    rst = 1'b0;
    drive(8'hFF, 8'hFF, 6);
    check_val("mrst_no_cap_valid", digit_valid, 8'h00);
    check_val("mrst_no_cap_seg", seg_q, 64'hFFFF_FFFF_FFFF_FFFF);

    // frame wrap 0->1->2->3->0
    strobe_cnt = 0;
    drive(8'hFE, 8'hC0, 6);
    drive(8'hFD, 8'hF9, 6);
    drive(8'hFB, 8'hA4, 6);
    drive(8'hF7, 8'hB0, 6);
    check_val("wrap_no_strobe_yet", strobe_cnt, 0);
    drive(8'hFE, 8'h99, 6);
    drive(8'hFF, 8'hFF, 3);
    check_val("wrap_strobes", strobe_cnt, 1);
    check_val("wrap_strobe_mask", strobe_mask, 8'h0F);
    check_val("wrap_strobe_slot0", strobe_slot0, 8'h99);
    check_val("wrap_fmask", frame_mask, 8'h0F);
    check_val("wrap_seg_q", seg_q, 64'hFFFF_FFFF_B0A4_F999);
    check_val("wrap_valid", digit_valid, 8'h0F);
    check_val("wrap_hex", hex, HEX_ON ? 32'h0000_3214 : 32'h0);
    check_val("wrap_hex_ok", hex_ok, HEX_ON ? 8'h0F : 8'h00);

    // idle after exactly 16 NONE samples, cleared by a ONE sample
    drive(8'hFE, 8'hC0, 3);
    drive(8'hFF, 8'hFF, 16);
    check_val("idle_before", idle, 1'b0);
    step();
    check_val("idle_at_16", idle, 1'b1);
    drive(8'hFF, 8'hFF, 3);
    check_val("idle_hold", idle, 1'b1);
    drive(8'hFE, 8'hC0, 1);
    check_val("idle_one_sampled", idle, 1'b1);
    step();
    check_val("idle_cleared", idle, 1'b0);
    check_val("idle_seg_q", seg_q, 64'hFFFF_FFFF_B0A4_F999);

    // error counter saturation
    for (int k = 0; k < 260; k++) begin
      drive(8'hFC, 8'hFF, 1);
      drive(8'hFE, 8'hFF, 1);
    end
    drive(8'hFF, 8'hFF, 3);
    check_val("err_cnt_sat", err_cnt, 8'hFF);
    check_val("sat_seg_q", seg_q, 64'hFFFF_FFFF_B0A4_F999);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
